// File: rtl/prefetch_pkg.sv
// -----------------------------------------------------------------------------
// prefetch_pkg
// Shared definitions for the 8088 prefetch queue:
//   - pf_state_e  : fetch FSM states (IDLE, FETCH, DISCARD)
//   - DEPTH       : queue depth in bytes (fixed, Instruction is 32 bits wide)
//   - DEPTH_CNT   : DEPTH at the width of the byte counter
//   - operacion_e : bus direction encoding, shared with bench-side interfaces
//   - phys_addr   : 8088 segment:offset to 20-bit physical address
// -----------------------------------------------------------------------------
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } pf_state_e;

    localparam int DEPTH = 4;
    localparam logic [2:0] DEPTH_CNT = 3'd4;

    typedef enum logic {
        LEER     = 1'b0,
        ESCRIBIR = 1'b1
    } operacion_e;

    // Segment shifted left by 4 plus offset; the carry out of bit 19 is dropped.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/prefetch_queue_8088.sv
// -----------------------------------------------------------------------------
// prefetch_queue_8088
// Prefetch stage in front of the 8088 decoder. Fetches code bytes at CS:IP over
// an 8-bit bus into a 4-byte queue and presents the oldest four bytes as a
// 32-bit Instruction word (byte0 = oldest in [7:0], empty slots read 0).
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   CS                   code segment, sampled whenever a request is launched
//   Flush, Flush_IP      discard the queue and redirect fetch to Flush_IP
//   Mem_Req, Mem_Addr    read request (held until Mem_Ack) and its address
//   RD_WR                bus direction, always read
//   Mem_Ack, Mem_Data    memory returns Mem_Data on the edge with Mem_Ack=1
//   Consume, Consume_N   decoder removes Consume_N (0-4) bytes this cycle
//   Instruction          queue window
//   Valid_Bytes          number of valid bytes in the queue
//   Instr_IP             IP of byte0
//   Underflow            one-cycle pulse when more bytes are consumed than held
// -----------------------------------------------------------------------------
module prefetch_queue_8088
    import prefetch_pkg::*;
#(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] CS,
    input  logic        Flush,
    input  logic [15:0] Flush_IP,
    output logic        Mem_Req,
    output logic [19:0] Mem_Addr,
    output logic        RD_WR,
    input  logic        Mem_Ack,
    input  logic [7:0]  Mem_Data,
    input  logic        Consume,
    input  logic [2:0]  Consume_N,
    output logic [31:0] Instruction,
    output logic [2:0]  Valid_Bytes,
    output logic [15:0] Instr_IP,
    output logic        Underflow
);

    pf_state_e   state_r;
    logic [31:0] queue_r;
    logic [2:0]  count_r;
    logic [15:0] fetch_ip_r;
    logic [15:0] instr_ip_r;
    logic        mem_req_r;
    logic [19:0] mem_addr_r;
    logic        underflow_r;

    logic        ack_s;
    logic        underflow_s;
    logic [2:0]  consumed_s;
    logic [2:0]  base_cnt_s;
    logic [2:0]  new_cnt_s;
    logic [31:0] queue_next_s;
    logic [15:0] launch_ip_s;
    logic [19:0] launch_addr_s;

    // Decode consume legality, shift the window and merge an arriving byte.
    always_comb begin
        underflow_s   = 1'b0;
        consumed_s    = 3'd0;
        // Only an ack against a live (non-discarded) request delivers a byte.
        ack_s         = (state_r == FETCH) && Mem_Ack;

        if (Consume) begin
            if (Consume_N > count_r) begin
                underflow_s = 1'b1;
            end else begin
                consumed_s = Consume_N;
            end
        end else begin
            consumed_s = 3'd0;
        end

        base_cnt_s   = count_r - consumed_s;
        new_cnt_s    = base_cnt_s + {2'b00, ack_s};
        // Logical shift zero-fills the top; a shift of 32 empties the window.
        queue_next_s = queue_r >> {consumed_s, 3'b000};

        // The new byte lands just above the bytes that survive the consume.
        if (ack_s) begin
            case (base_cnt_s)
                3'd0:    queue_next_s[7:0]   = Mem_Data;
                3'd1:    queue_next_s[15:8]  = Mem_Data;
                3'd2:    queue_next_s[23:16] = Mem_Data;
                3'd3:    queue_next_s[31:24] = Mem_Data;
                default: queue_next_s[7:0]   = queue_next_s[7:0];
            endcase
        end else begin
            queue_next_s[7:0] = queue_next_s[7:0];
        end

        launch_ip_s   = fetch_ip_r + {15'd0, ack_s};
        launch_addr_s = phys_addr(CS, launch_ip_s);
    end

    // Fetch FSM, byte queue, IP tracking and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            queue_r     <= 32'h0000_0000;
            count_r     <= 3'd0;
            fetch_ip_r  <= RESET_IP;
            instr_ip_r  <= RESET_IP;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 20'h0_0000;
            underflow_r <= 1'b0;
        end else if (Flush) begin
            queue_r     <= 32'h0000_0000;
            count_r     <= 3'd0;
            fetch_ip_r  <= Flush_IP;
            instr_ip_r  <= Flush_IP;
            underflow_r <= 1'b0;
            case (state_r)
                // An outstanding request must still complete on the bus; its
                // byte belongs to the old stream and is thrown away.
                FETCH: begin
                    if (Mem_Ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (Mem_Ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= DISCARD;
                    end
                end
                IDLE: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end else begin
            queue_r     <= queue_next_s;
            count_r     <= new_cnt_s;
            fetch_ip_r  <= launch_ip_s;
            instr_ip_r  <= instr_ip_r + {13'd0, consumed_s};
            underflow_r <= underflow_s;
            case (state_r)
                IDLE: begin
                    if (new_cnt_s < DEPTH_CNT) begin
                        state_r    <= FETCH;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= launch_addr_s;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                FETCH: begin
                    if (Mem_Ack) begin
                        if (new_cnt_s < DEPTH_CNT) begin
                            // Back-to-back relaunch at the next byte address.
                            state_r    <= FETCH;
                            mem_addr_r <= launch_addr_s;
                        end else begin
                            state_r    <= IDLE;
                            mem_req_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DISCARD: begin
                    if (Mem_Ack) begin
                        state_r   <= IDLE;
                        mem_req_r <= 1'b0;
                    end else begin
                        state_r   <= DISCARD;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign Mem_Req     = mem_req_r;
    assign Mem_Addr    = mem_addr_r;
    assign RD_WR       = LEER;
    assign Instruction = queue_r;
    assign Valid_Bytes = count_r;
    assign Instr_IP    = instr_ip_r;
    assign Underflow   = underflow_r;

endmodule

// File: tb/tb_prefetch_queue_8088.sv
module tb_prefetch_queue_8088;

    logic        clk;
    logic        reset;
    logic [15:0] CS;
    logic        Flush;
    logic [15:0] Flush_IP;
    logic        Mem_Req;
    logic [19:0] Mem_Addr;
    logic        RD_WR;
    logic        Mem_Ack;
    logic [7:0]  Mem_Data;
    logic        Consume;
    logic [2:0]  Consume_N;
    logic [31:0] Instruction;
    logic [2:0]  Valid_Bytes;
    logic [15:0] Instr_IP;
    logic        Underflow;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        flush;
        logic [15:0] flush_ip;
        logic [15:0] cs;
        logic        ack;
        logic [7:0]  data;
        logic        consume;
        logic [2:0]  n;
        logic        e_req;
        logic [19:0] e_addr;
        logic [2:0]  e_valid;
        logic [31:0] e_instr;
        logic [15:0] e_ip;
        logic        e_uf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    prefetch_queue_8088 dut (
        .clk        (clk),
        .reset      (reset),
        .CS         (CS),
        .Flush      (Flush),
        .Flush_IP   (Flush_IP),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .RD_WR      (RD_WR),
        .Mem_Ack    (Mem_Ack),
        .Mem_Data   (Mem_Data),
        .Consume    (Consume),
        .Consume_N  (Consume_N),
        .Instruction(Instruction),
        .Valid_Bytes(Valid_Bytes),
        .Instr_IP   (Instr_IP),
        .Underflow  (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic req, input logic [19:0] addr,
                             input logic [2:0] valid, input logic [31:0] instr,
                             input logic [15:0] ip, input logic uf);
        check({tag, " Mem_Req"},     {31'd0, Mem_Req},     {31'd0, req});
        check({tag, " Mem_Addr"},    {12'd0, Mem_Addr},    {12'd0, addr});
        check({tag, " Valid_Bytes"}, {29'd0, Valid_Bytes}, {29'd0, valid});
        check({tag, " Instruction"}, Instruction,          instr);
        check({tag, " Instr_IP"},    {16'd0, Instr_IP},    {16'd0, ip});
        check({tag, " Underflow"},   {31'd0, Underflow},   {31'd0, uf});
        check({tag, " RD_WR"},       {31'd0, RD_WR},       32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            flush fip       cs        ack data   con n     req addr        vb    instr          ip        uf
        // Fill from CS=FFFF with zero-wait acks.
        vecs[0]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'hFFFF0, 3'd0, 32'h00000000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hA1, 1'b0, 3'd0, 1'b1, 20'hFFFF1, 3'd1, 32'h000000A1, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hB2, 1'b0, 3'd0, 1'b1, 20'hFFFF2, 3'd2, 32'h0000B2A1, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hC3, 1'b0, 3'd0, 1'b1, 20'hFFFF3, 3'd3, 32'h00C3B2A1, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hD4, 1'b0, 3'd0, 1'b0, 20'hFFFF3, 3'd4, 32'hD4C3B2A1, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 20'hFFFF3, 3'd4, 32'hD4C3B2A1, 16'h0000, 1'b0};
        // Stray ack with no request is ignored.
        vecs[6]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'h99, 1'b0, 3'd0, 1'b0, 20'hFFFF3, 3'd4, 32'hD4C3B2A1, 16'h0000, 1'b0};
        // Consume 2 from a full queue, refetch starts at FFFF4.
        vecs[7]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 20'hFFFF4, 3'd2, 32'h0000D4C3, 16'h0002, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hE5, 1'b0, 3'd0, 1'b1, 20'hFFFF5, 3'd3, 32'h00E5D4C3, 16'h0002, 1'b0};
        // Consume 1 and ack on the same edge.
        vecs[9]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'hF6, 1'b1, 3'd1, 1'b1, 20'hFFFF6, 3'd3, 32'h00F6E5D4, 16'h0003, 1'b0};
        // Over-consume -> Underflow pulse, queue untouched.
        vecs[10] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 20'hFFFF6, 3'd3, 32'h00F6E5D4, 16'h0003, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'hFFFF6, 3'd3, 32'h00F6E5D4, 16'h0003, 1'b0};
        // Consume_N = 0 is a no-op.
        vecs[12] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 20'hFFFF6, 3'd3, 32'h00F6E5D4, 16'h0003, 1'b0};
        // Flush during unacked request: DISCARD, then drop the byte, then relaunch.
        vecs[13] = '{1'b1, 16'h0100, 16'h2000, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'hFFFF6, 3'd0, 32'h00000000, 16'h0100, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 16'h2000, 1'b1, 8'h77, 1'b0, 3'd0, 1'b0, 20'hFFFF6, 3'd0, 32'h00000000, 16'h0100, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 16'h2000, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h20100, 3'd0, 32'h00000000, 16'h0100, 1'b0};
        // Flush on the same edge as ack: byte dropped, straight to IDLE.
        vecs[16] = '{1'b1, 16'hFFFF, 16'h1000, 1'b1, 8'h55, 1'b0, 3'd0, 1'b0, 20'h20100, 3'd0, 32'h00000000, 16'hFFFF, 1'b0};
        // IP wrap FFFF -> 0000 inside CS=1000.
        vecs[17] = '{1'b0, 16'h0000, 16'h1000, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h1FFFF, 3'd0, 32'h00000000, 16'hFFFF, 1'b0};
        vecs[18] = '{1'b0, 16'h0000, 16'h1000, 1'b1, 8'h11, 1'b0, 3'd0, 1'b1, 20'h10000, 3'd1, 32'h00000011, 16'hFFFF, 1'b0};
        vecs[19] = '{1'b0, 16'h0000, 16'h1000, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 20'h10000, 3'd0, 32'h00000000, 16'h0000, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 16'h1000, 1'b1, 8'h22, 1'b0, 3'd0, 1'b1, 20'h10001, 3'd1, 32'h00000022, 16'h0000, 1'b0};
        // Valid_Bytes=1, Consume_N=3 -> one-cycle Underflow.
        vecs[21] = '{1'b0, 16'h0000, 16'h1000, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 20'h10001, 3'd1, 32'h00000022, 16'h0000, 1'b1};
        vecs[22] = '{1'b0, 16'h0000, 16'h1000, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h10001, 3'd1, 32'h00000022, 16'h0000, 1'b0};
        // Second flush in DISCARD retargets only; physical carry beyond 20 bits dropped.
        vecs[23] = '{1'b1, 16'h0010, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h10001, 3'd0, 32'h00000000, 16'h0010, 1'b0};
        vecs[24] = '{1'b1, 16'h0020, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h10001, 3'd0, 32'h00000000, 16'h0020, 1'b0};
        vecs[25] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 8'h33, 1'b0, 3'd0, 1'b0, 20'h10001, 3'd0, 32'h00000000, 16'h0020, 1'b0};
        vecs[26] = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 20'h00010, 3'd0, 32'h00000000, 16'h0020, 1'b0};

        reset     = 1'b1;
        CS        = 16'hFFFF;
        Flush     = 1'b0;
        Flush_IP  = 16'h0000;
        Mem_Ack   = 1'b0;
        Mem_Data  = 8'h00;
        Consume   = 1'b0;
        Consume_N = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 20'h00000, 3'd0, 32'h0, 16'h0000, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            Flush     = vecs[i].flush;
            Flush_IP  = vecs[i].flush_ip;
            CS        = vecs[i].cs;
            Mem_Ack   = vecs[i].ack;
            Mem_Data  = vecs[i].data;
            Consume   = vecs[i].consume;
            Consume_N = vecs[i].n;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                      vecs[i].e_instr, vecs[i].e_ip, vecs[i].e_uf);
        end

        // Reset asserted mid-FETCH: Mem_Req drops without waiting for a clock.
        Flush   = 1'b0;
        Mem_Ack = 1'b0;
        Consume = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async reset Mem_Req", {31'd0, Mem_Req}, 32'd0);
        check("async reset Mem_Addr", {12'd0, Mem_Addr}, 32'd0);
        // Pending ack arriving under reset is ignored.
        Mem_Ack  = 1'b1;
        Mem_Data = 8'hEE;
        @(posedge clk);
        #1;
        check_all("in reset", 1'b0, 20'h00000, 3'd0, 32'h0, 16'h0000, 1'b0);
        reset   = 1'b0;
        Mem_Ack = 1'b0;
        CS      = 16'h1234;
        @(posedge clk);
        #1;
        check_all("after reset", 1'b1, 20'h12340, 3'd0, 32'h0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
